accel_spi_responder: RTL and testbench

- SPI mode-0 slave that models the accelerometer's register interface, i.e. the responder side of the read/write register protocol our SPI master drives.
- Oversamples sclk, nCS and mosi in the system clock domain and decodes command, address and data bytes.
- Returns register contents on miso, and accepts writes to a small writable bank.
- Used as a bench/bring-up stand-in for the sensor, and as a loopback target on the board.

---
 rtl/accel_spi_responder_pkg.sv | 30 +++
 rtl/accel_spi_responder_if.sv | 11 +
 rtl/accel_spi_responder_spi_sync_edge.sv | 31 +++
 rtl/accel_spi_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_spi_responder_pkg.sv
// Shared constants, FSM encoding and address helpers for the accelerometer SPI responder.
package accel_spi_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h0A;
  localparam logic [7:0] CMD_READ    = 8'h0B;

  localparam logic [7:0] ADDR_DEVID  = 8'h00;
  localparam logic [7:0] ADDR_XDATA  = 8'h08;
  localparam logic [7:0] ADDR_YDATA  = 8'h09;
  localparam logic [7:0] ADDR_ZDATA  = 8'h0A;
  localparam logic [7:0] ADDR_STATUS = 8'h0B;

  localparam int WR_BANK_SIZE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR_R = 3'd2,
    ST_ADDR_W = 3'd3,
    ST_READ   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_IGNORE = 3'd6
  } spi_state_e;

  // Offset compare wraps mod 256, so any base (aligned or not) works.
  function automatic logic in_wr_bank(input logic [7:0] addr, input logic [7:0] base);
    return (8'(addr - base) < 8'd16);
  endfunction

endpackage

// File: rtl/accel_spi_responder_if.sv
// SPI bus between the board master and the accelerometer responder.
// Framing: nCS low opens a transaction; mosi is sampled on sclk rise, miso changes on sclk fall (mode 0).
interface accel_spi_responder_if;
  logic sclk;
  logic nCS;
  logic mosi;
  logic miso;

  modport master (output sclk, output nCS, output mosi, input miso);
  modport slave  (input sclk, input nCS, input mosi, output miso);
endinterface

// File: rtl/accel_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a rise/fall edge detector.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic ck,
  input  logic reset,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              level;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 responder emulating the accelerometer register map (read/write, auto-increment).
// Optional: define ACCEL_SPI_RESP_STATUS_EN to expose a data_ready flag at address 0x0B.
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hAD,
  parameter logic [7:0] WR_BASE     = 8'h20
) (
  input  logic                    ck,
  input  logic                    reset,
  accel_spi_responder_if.slave    spi,
  input  logic [7:0]              x_data,
  input  logic [7:0]              y_data,
  input  logic [7:0]              z_data,
  input  logic                    sample_en,
  output logic                    busy,
  output logic                    wr_pulse,
  output logic [7:0]              wr_addr,
  output logic [7:0]              wr_data,
  output spi_state_e              state_o
);

  logic sclk_rise, sclk_fall;
  logic ncs_rise, ncs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .ck      (ck),
    .reset   (reset),
    .async_i (spi.sclk),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
    .ck      (ck),
    .reset   (reset),
    .async_i (spi.nCS),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  // mosi skips the edge flop so it lines up with the sclk rise event.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] addr_q;
  logic [7:0] rx_q;
  logic [7:0] rx_d;
  logic [7:0] tx_q;
  logic       load_q;
  logic       miso_q;
  logic       busy_q;
  logic       wr_pulse_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] bank_q [WR_BANK_SIZE];
  logic       byte_done;

  logic [7:0] x_sh_q, y_sh_q, z_sh_q;
  logic [7:0] x_pend_q, y_pend_q, z_pend_q;
  logic       pend_q;
  logic [7:0] rd_byte;

  assign rx_d      = {rx_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

`ifdef ACCEL_SPI_RESP_STATUS_EN
  logic dr_q;
  logic shadow_upd;
  logic dr_clr;

  assign shadow_upd = !busy_q && (sample_en || pend_q);
  assign dr_clr     = (state_q == ST_READ) && !ncs_rise && byte_done && (addr_q == ADDR_ZDATA);

  // A fresh sample takes priority over the read-side clear.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      dr_q <= 1'b0;
    end else if (shadow_upd) begin
      dr_q <= 1'b1;
    end else if (dr_clr) begin
      dr_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    rd_byte = 8'h00;
    if (in_wr_bank(addr_q, WR_BASE)) begin
      rd_byte = bank_q[4'(addr_q - WR_BASE)];
    end
    case (addr_q)
      ADDR_DEVID:  rd_byte = DEVID;
      ADDR_XDATA:  rd_byte = x_sh_q;
      ADDR_YDATA:  rd_byte = y_sh_q;
      ADDR_ZDATA:  rd_byte = z_sh_q;
`ifdef ACCEL_SPI_RESP_STATUS_EN
      ADDR_STATUS: rd_byte = {7'b0, dr_q};
`endif
      default: ;
    endcase
  end

  // Shadows only move while no transaction is open, so a burst never sees a torn sample.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      z_sh_q   <= '0;
      x_pend_q <= '0;
      y_pend_q <= '0;
      z_pend_q <= '0;
      pend_q   <= 1'b0;
    end else if (sample_en && busy_q) begin
      pend_q   <= 1'b1;
      x_pend_q <= x_data;
      y_pend_q <= y_data;
      z_pend_q <= z_data;
    end else if (sample_en) begin
      x_sh_q <= x_data;
      y_sh_q <= y_data;
      z_sh_q <= z_data;
      pend_q <= 1'b0;
    end else if (pend_q && !busy_q) begin
      x_sh_q <= x_pend_q;
      y_sh_q <= y_pend_q;
      z_sh_q <= z_pend_q;
      pend_q <= 1'b0;
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      load_q     <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < WR_BANK_SIZE; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      wr_pulse_q <= 1'b0;
      if (ncs_fall) begin
        busy_q <= 1'b1;
      end else if (ncs_rise) begin
        busy_q <= 1'b0;
      end

      // Deselect wins over everything, including a coincident last sclk rise.
      if (ncs_rise) begin
        state_q   <= ST_IDLE;
        miso_q    <= 1'b0;
        bit_cnt_q <= '0;
        load_q    <= 1'b0;
      end else begin
        if (sclk_rise && (state_q != ST_IDLE) && (state_q != ST_IGNORE)) begin
          rx_q      <= rx_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end

        case (state_q)
          ST_IDLE: begin
            if (ncs_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= '0;
              miso_q    <= 1'b0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              case (rx_d)
                CMD_READ:  state_q <= ST_ADDR_R;
                CMD_WRITE: state_q <= ST_ADDR_W;
                default:   state_q <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR_R: begin
            if (byte_done) begin
              addr_q  <= rx_d;
              load_q  <= 1'b1;
              state_q <= ST_READ;
            end
          end
          ST_ADDR_W: begin
            if (byte_done) begin
              addr_q  <= rx_d;
              state_q <= ST_WRITE;
            end
          end
          ST_READ: begin
            // The fall after each byte boundary loads the next register.
            if (sclk_fall) begin
              if (load_q) begin
                miso_q <= rd_byte[7];
                tx_q   <= {rd_byte[6:0], 1'b0};
                load_q <= 1'b0;
              end else begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end
            if (byte_done) begin
              addr_q <= addr_q + 8'd1;
              load_q <= 1'b1;
            end
          end
          ST_WRITE: begin
            if (byte_done) begin
              if (in_wr_bank(addr_q, WR_BASE)) begin
                bank_q[4'(addr_q - WR_BASE)] <= rx_d;
                wr_pulse_q <= 1'b1;
                wr_addr_q  <= addr_q;
                wr_data_q  <= rx_d;
              end
              addr_q <= addr_q + 8'd1;
            end
          end
          ST_IGNORE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Gating with the raw pin keeps miso low the moment the master deselects.
  assign spi.miso = miso_q & ~spi.nCS;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Bench for accel_spi_responder: bit-banged SPI master, register-map model and write scoreboard.
module tb_accel_spi_responder;
  import accel_spi_pkg::*;

  localparam int HALF = 6;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic reset = 1'b0;
  always #5 ck = ~ck;

  accel_spi_responder_if spi_if ();

  logic [7:0] x_data, y_data, z_data;
  logic       sample_en;
  logic       busy, wr_pulse;
  logic [7:0] wr_addr, wr_data;
  spi_state_e state_o;

  accel_spi_responder #(.SYNC_STAGES(2), .DEVID(8'hAD), .WR_BASE(8'h20)) dut (
    .ck        (ck),
    .reset     (reset),
    .spi       (spi_if),
    .x_data    (x_data),
    .y_data    (y_data),
    .z_data    (z_data),
    .sample_en (sample_en),
    .busy      (busy),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .state_o   (state_o)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int pulse_cnt = 0;

  // ---------------- reference model ----------------
  logic [7:0]  m_bank [16];
  logic [7:0]  m_x, m_y, m_z;
  logic [7:0]  m_px, m_py, m_pz;
  logic        m_dr, m_pend;
  logic        in_xact;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  wr_bytes[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
    m_x = 0; m_y = 0; m_z = 0; m_px = 0; m_py = 0; m_pz = 0;
    m_dr = 0; m_pend = 0; in_xact = 0;
    exp_q.delete();
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return 8'hAD;
    if (a == 8'h08) return m_x;
    if (a == 8'h09) return m_y;
    if (a == 8'h0A) return m_z;
`ifdef ACCEL_SPI_RESP_STATUS_EN
    if (a == 8'h0B) return {7'b0, m_dr};
`endif
    if (a >= 8'h20 && a <= 8'h2F) return m_bank[a[3:0]];
    return 8'h00;
  endfunction

  task automatic model_burst(input logic [7:0] addr, input int n);
    logic [7:0] a;
    a = addr;
    exp_rd.delete();
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(model_read(a));
      if (a == 8'h0A) m_dr = 1'b0;
      a = a + 8'd1;
    end
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a >= 8'h20 && a <= 8'h2F) begin
      m_bank[a[3:0]] = d;
      exp_q.push_back({a, d});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_if.mosi = tx[7-i];
      tick(HALF);
      rx = {rx[6:0], spi_if.miso};
      spi_if.sclk = 1'b1;
      tick(HALF);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    spi_if.nCS = 1'b0;
    in_xact = 1'b1;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    spi_if.nCS = 1'b1;
    tick(12);
    in_xact = 1'b0;
    if (m_pend) begin
      m_x = m_px; m_y = m_py; m_z = m_pz; m_dr = 1'b1; m_pend = 1'b0;
    end
  endtask

  task automatic sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    x_data = x; y_data = y; z_data = z;
    sample_en = 1'b1;
    tick(1);
    sample_en = 1'b0;
    if (in_xact) begin
      m_pend = 1'b1; m_px = x; m_py = y; m_pz = z;
    end else begin
      m_x = x; m_y = y; m_z = z; m_dr = 1'b1;
    end
  endtask

  task automatic spi_read(input logic [7:0] addr, input int n);
    logic [7:0] rx;
    rd_q.delete();
    cs_begin();
    xfer(CMD_READ, rx);
    xfer(addr, rx);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      rd_q.push_back(rx);
    end
    cs_end();
  endtask

  task automatic spi_write(input logic [7:0] addr);
    logic [7:0] rx;
    logic [7:0] a;
    a = addr;
    cs_begin();
    xfer(CMD_WRITE, rx);
    xfer(addr, rx);
    foreach (wr_bytes[i]) begin
      model_write(a, wr_bytes[i]);
      xfer(wr_bytes[i], rx);
      a = a + 8'd1;
    end
    cs_end();
  endtask

  // ---------------- write scoreboard ----------------
  always @(negedge ck) begin
    if (reset && wr_pulse === 1'b1) begin
      logic [15:0] e;
      pulse_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wr_pulse_unexpected got=%02h/%02h exp=none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          tests_failed++;
          $display("FAIL wr_commit got=%02h/%02h exp=%02h/%02h", wr_addr, wr_data, e[15:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(3);
    tests_run++;
    if (busy !== 1'b0 || wr_pulse !== 1'b0 || spi_if.miso !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b%b%b exp=000", busy, wr_pulse, spi_if.miso);
    end
    tests_run++;
    if (wr_addr !== 8'h00 || wr_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_wr got=%02h/%02h exp=00/00", wr_addr, wr_data);
    end
    tests_run++;
    if (state_o !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_IDLE);
    end
    reset = 1'b1;
    tick(4);
    tests_run++;
    if (busy !== 1'b0 || state_o !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL post_reset got=%b/%0d exp=0/%0d", busy, state_o, ST_IDLE);
    end
  endtask

  task automatic test_devid();
    logic [7:0] rx;
    cs_begin();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_start got=%b exp=1", busy);
    end
    xfer(CMD_READ, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    tests_run++;
    if (rx !== 8'hAD) begin
      tests_failed++;
      $display("FAIL devid got=%02h exp=AD", rx);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_mid got=%b exp=1", busy);
    end
    tick(HALF);
    spi_if.nCS = 1'b1;
    tick(2);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_hold_2ck got=%b exp=1", busy);
    end
    tick(1);
    tests_run++;
    if (busy !== 1'b0 || spi_if.miso !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_drop_3ck got=%b/%b exp=0/0", busy, spi_if.miso);
    end
    tick(10);
    in_xact = 1'b0;
  endtask

  task automatic test_burst_read();
    logic [7:0] x, y, z;
    x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
    sample(8'h12, 8'h34, 8'h56);
    spi_read(8'h08, 3);
    model_burst(8'h08, 3);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rd_q[i] !== exp_rd[i]) begin
        tests_failed++;
        $display("FAIL burst_fixed[%0d] got=%02h exp=%02h", i, rd_q[i], exp_rd[i]);
      end
    end
    sample(x, y, z);
    spi_read(8'h08, 3);
    model_burst(8'h08, 3);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rd_q[i] !== exp_rd[i]) begin
        tests_failed++;
        $display("FAIL burst_rand[%0d] got=%02h exp=%02h", i, rd_q[i], exp_rd[i]);
      end
    end
  endtask

  task automatic test_write();
    int p0;
    p0 = pulse_cnt;
    wr_bytes = '{8'h5A, 8'hC3};
    spi_write(8'h2E);
    tests_run++;
    if (pulse_cnt - p0 != 2) begin
      tests_failed++;
      $display("FAIL write_pulses got=%0d exp=2", pulse_cnt - p0);
    end
    tests_run++;
    if (wr_addr !== 8'h2F || wr_data !== 8'hC3) begin
      tests_failed++;
      $display("FAIL write_last got=%02h/%02h exp=2F/C3", wr_addr, wr_data);
    end
    spi_read(8'h2E, 2);
    tests_run++;
    if (rd_q[0] !== 8'h5A || rd_q[1] !== 8'hC3) begin
      tests_failed++;
      $display("FAIL write_readback got=%02h/%02h exp=5A/C3", rd_q[0], rd_q[1]);
    end
  endtask

  task automatic test_sample_during_read();
    logic [7:0] rx, old_x;
    old_x = m_x;
    cs_begin();
    xfer(CMD_READ, rx);
    xfer(8'h08, rx);
    sample(8'h77, 8'($urandom), 8'($urandom));
    xfer(8'h00, rx);
    tests_run++;
    if (rx !== old_x) begin
      tests_failed++;
      $display("FAIL no_tear got=%02h exp=%02h", rx, old_x);
    end
    cs_end();
    spi_read(8'h08, 1);
    tests_run++;
    if (rd_q[0] !== 8'h77) begin
      tests_failed++;
      $display("FAIL pending_apply got=%02h exp=77", rd_q[0]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx, d;
    int p0;
    p0 = pulse_cnt;
    wr_bytes = '{8'($urandom)};
    spi_write(8'h08);
    // partial byte to 0x21
    d = 8'($urandom_range(1, 255));
    cs_begin();
    xfer(CMD_WRITE, rx);
    xfer(8'h21, rx);
    xfer_bits(d, 4, rx);
    cs_end();
    // last sclk rise coincides with nCS rise on 0x22
    cs_begin();
    xfer(CMD_WRITE, rx);
    xfer(8'h22, rx);
    xfer_bits(d, 7, rx);
    spi_if.mosi = d[0];
    tick(HALF);
    spi_if.sclk = 1'b1;
    spi_if.nCS = 1'b1;
    tick(HALF);
    spi_if.sclk = 1'b0;
    tick(12);
    in_xact = 1'b0;
    tests_run++;
    if (pulse_cnt != p0) begin
      tests_failed++;
      $display("FAIL abort_pulses got=%0d exp=0", pulse_cnt - p0);
    end
    spi_read(8'h21, 2);
    tests_run++;
    if (rd_q[0] !== 8'h00 || rd_q[1] !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_bank got=%02h/%02h exp=00/00", rd_q[0], rd_q[1]);
    end
    cs_begin();
    xfer(8'hFF, rx);
    tests_run++;
    if (state_o !== ST_IGNORE) begin
      tests_failed++;
      $display("FAIL unknown_state got=%0d exp=%0d", state_o, ST_IGNORE);
    end
    for (int i = 0; i < 2; i++) begin
      xfer(8'($urandom), rx);
      tests_run++;
      if (rx !== 8'h00) begin
        tests_failed++;
        $display("FAIL unknown_miso[%0d] got=%02h exp=00", i, rx);
      end
    end
    cs_end();
  endtask

  task automatic test_status();
    sample(8'($urandom), 8'($urandom), 8'($urandom));
    model_burst(8'h0B, 1);
    spi_read(8'h0B, 1);
    tests_run++;
    if (rd_q[0] !== exp_rd[0]) begin
      tests_failed++;
      $display("FAIL status_set got=%02h exp=%02h", rd_q[0], exp_rd[0]);
    end
    model_burst(8'h08, 4);
    spi_read(8'h08, 4);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_q[i] !== exp_rd[i]) begin
        tests_failed++;
        $display("FAIL status_burst[%0d] got=%02h exp=%02h", i, rd_q[i], exp_rd[i]);
      end
    end
    model_burst(8'h0B, 1);
    spi_read(8'h0B, 1);
    tests_run++;
    if (rd_q[0] !== exp_rd[0]) begin
      tests_failed++;
      $display("FAIL status_clr got=%02h exp=%02h", rd_q[0], exp_rd[0]);
    end
  endtask

  task automatic test_wrap();
    model_burst(8'hFF, 2);
    spi_read(8'hFF, 2);
    tests_run++;
    if (rd_q[0] !== exp_rd[0] || rd_q[1] !== exp_rd[1]) begin
      tests_failed++;
      $display("FAIL addr_wrap got=%02h/%02h exp=%02h/%02h", rd_q[0], rd_q[1], exp_rd[0], exp_rd[1]);
    end
    wr_bytes = '{8'($urandom), 8'($urandom)};
    spi_write(8'h2F);
    spi_read(8'h2F, 2);
    model_burst(8'h2F, 2);
    tests_run++;
    if (rd_q[0] !== exp_rd[0] || rd_q[1] !== exp_rd[1]) begin
      tests_failed++;
      $display("FAIL bank_edge got=%02h/%02h exp=%02h/%02h", rd_q[0], rd_q[1], exp_rd[0], exp_rd[1]);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] rx;
    cs_begin();
    xfer(CMD_WRITE, rx);
    xfer(8'h2E, rx);
    xfer_bits(8'hA5, 5, rx);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (state_o !== ST_IDLE || wr_addr !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got=%0d/%02h/%b exp=%0d/00/0", state_o, wr_addr, busy, ST_IDLE);
    end
    spi_if.nCS = 1'b1;
    spi_if.sclk = 1'b0;
    model_reset();
    tick(3);
    reset = 1'b1;
    tick(4);
    model_burst(8'h2E, 2);
    spi_read(8'h2E, 2);
    tests_run++;
    if (rd_q[0] !== exp_rd[0] || rd_q[1] !== exp_rd[1]) begin
      tests_failed++;
      $display("FAIL reset_bank got=%02h/%02h exp=%02h/%02h", rd_q[0], rd_q[1], exp_rd[0], exp_rd[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    int n, op;
    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 3);
      if (op == 0) begin
        a = 8'($urandom_range(8'h1C, 8'h33));
        wr_bytes.delete();
        for (int k = 0; k < n; k++) wr_bytes.push_back(8'($urandom));
        spi_write(a);
      end else if (op == 1) begin
        a = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(8'h06, 8'h2F));
        model_burst(a, n);
        spi_read(a, n);
        for (int k = 0; k < n; k++) begin
          tests_run++;
          if (rd_q[k] !== exp_rd[k]) begin
            tests_failed++;
            $display("FAIL rand_read it=%0d addr=%02h got=%02h exp=%02h", it, 8'(a + 8'(k)), rd_q[k], exp_rd[k]);
          end
        end
      end else begin
        sample(8'($urandom), 8'($urandom), 8'($urandom));
        tick(2);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    spi_if.sclk = 1'b0;
    spi_if.nCS  = 1'b1;
    spi_if.mosi = 1'b0;
    x_data = 0; y_data = 0; z_data = 0;
    sample_en = 1'b0;
    model_reset();
    test_reset();
    test_devid();
    test_burst_read();
    test_write();
    test_sample_during_read();
    test_abort();
    test_status();
    test_wrap();
    test_async_reset();
    test_random();
    tick(10);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_commits got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
